// File: rtl/comp_4bit_if.sv
// Operand/cascade bus for the registered magnitude comparator.
// The master drives operands and cascade flags; the slave (comparator)
// returns the registered result flags and their valid strobe.
interface comp_4bit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cas_gt;
    logic             cas_eq;
    logic             cas_lt;
    logic             out_valid;
    logic             agtb;
    logic             aeqb;
    logic             altb;

    modport master (
        output in_valid, a, b, cas_gt, cas_eq, cas_lt,
        input  out_valid, agtb, aeqb, altb
    );

    modport slave (
        input  in_valid, a, b, cas_gt, cas_eq, cas_lt,
        output out_valid, agtb, aeqb, altb
    );
endinterface

// File: rtl/comp_4bit.sv
// Registered unsigned magnitude comparator with cascade inputs.
// One-hot {agtb, aeqb, altb} appear one clock after a valid sample; equal
// operands defer to the cascade flags from a less-significant stage, so
// several instances can be chained into a wider comparator.
module comp_4bit #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    comp_4bit_if.slave bus
);

    // Resolve one compare into {gt, eq, lt}; equal operands fall through to
    // the cascade flags with greater taking priority over less.
    function automatic logic [2:0] resolve(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cgt,
        input logic             clt
    );
        logic [2:0] r;
        if (a > b)
            r = 3'b100;
        else if (a < b)
            r = 3'b001;
        else if (cgt)
            r = 3'b100;
        else if (clt)
            r = 3'b001;
        else
            r = 3'b010;
        return r;
    endfunction

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             vld_p0;
    logic [2:0]       flags_p0;
    logic             vld_p1;
    logic [2:0]       flags_p1;

    // cas_eq carries no extra information: equal operands with neither
    // cas_gt nor cas_lt set already resolve to equal.
    logic             cas_eq_unused;

    assign a_p0          = bus.a;
    assign b_p0          = bus.b;
    assign vld_p0        = bus.in_valid;
    assign cas_eq_unused = bus.cas_eq;

    // Stage p0: combinational compare of the sampled inputs.
    always_comb begin
        flags_p0 = resolve(a_p0, b_p0, bus.cas_gt, bus.cas_lt);
    end

    // Stage p1: register the result; flags hold while no valid sample arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            flags_p1 <= 3'b000;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)
                flags_p1 <= flags_p0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.agtb      = flags_p1[2];
    assign bus.aeqb      = flags_p1[1];
    assign bus.altb      = flags_p1[0];

endmodule

// File: tb/tb_comp_4bit.sv
// Directed and sweep checks for comp_4bit at WIDTH=4 and WIDTH=8.
module tb_comp_4bit;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    comp_4bit_if #(.WIDTH(4)) bus4 ();
    comp_4bit_if #(.WIDTH(8)) bus8 ();

    comp_4bit #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    comp_4bit #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got[3:0], exp[3:0]);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs4();
        return {bus4.out_valid, bus4.agtb, bus4.aeqb, bus4.altb};
    endfunction

    function automatic logic [3:0] obs8();
        return {bus8.out_valid, bus8.agtb, bus8.aeqb, bus8.altb};
    endfunction

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] cas);
        bus4.in_valid = v;
        bus4.a        = a;
        bus4.b        = b;
        bus4.cas_gt   = cas[2];
        bus4.cas_eq   = cas[1];
        bus4.cas_lt   = cas[0];
    endtask

    // Basic sequence vectors: a, b, expected {agtb,aeqb,altb}
    logic [3:0] seq_a   [6] = '{4'b0000, 4'b0010, 4'b0100, 4'b1111, 4'b0001, 4'b1100};
    logic [3:0] seq_b   [6] = '{4'b0000, 4'b0001, 4'b1000, 4'b1111, 4'b0010, 4'b1011};
    logic [2:0] seq_exp [6] = '{3'b010,  3'b100,  3'b001,  3'b010,  3'b001,  3'b100};

    // Cascade vectors: a, b, cas {gt,eq,lt}, expected flags
    logic [3:0] cas_a   [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0001};
    logic [3:0] cas_b   [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
    logic [2:0] cas_in  [6] = '{3'b100,  3'b001,  3'b010,  3'b101,  3'b000,  3'b001};
    logic [2:0] cas_exp [6] = '{3'b100,  3'b001,  3'b010,  3'b100,  3'b010,  3'b100};

    // Boundary vectors
    logic [3:0] edg_a   [3] = '{4'b1000, 4'b0000, 4'b1111};
    logic [3:0] edg_b   [3] = '{4'b0111, 4'b0001, 4'b1110};
    logic [2:0] edg_exp [3] = '{3'b100,  3'b001,  3'b100};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive4(1'b0, 4'd0, 4'd0, 3'b010);
        bus8.in_valid = 1'b0;
        bus8.a        = '0;
        bus8.b        = '0;
        bus8.cas_gt   = 1'b0;
        bus8.cas_eq   = 1'b1;
        bus8.cas_lt   = 1'b0;

        step();
        step();
        check("reset_w4", {28'd0, obs4()}, 32'h0);
        check("reset_w8", {28'd0, obs8()}, 32'h0);
        rst = 1'b0;

        // back-to-back basic sequence
        for (int i = 0; i < 6; i++) begin
            drive4(1'b1, seq_a[i], seq_b[i], 3'b010);
            step();
            check($sformatf("basic_%0d", i), {28'd0, obs4()}, {28'd0, 1'b1, seq_exp[i]});
        end

        // reset mid-stream discards the concurrent valid input
        drive4(1'b1, 4'b1100, 4'b1011, 3'b010);
        rst = 1'b1;
        step();
        check("rst_mid", {28'd0, obs4()}, 32'h0);
        rst = 1'b0;
        step();
        check("rst_release", {28'd0, obs4()}, {28'd0, 4'b1100});

        // hold on invalid
        drive4(1'b1, 4'b0100, 4'b1000, 3'b010);
        step();
        check("hold_load", {28'd0, obs4()}, {28'd0, 4'b1001});
        drive4(1'b0, 4'b1111, 4'b0000, 3'b010);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_%0d", i), {28'd0, obs4()}, {28'd0, 4'b0001});
        end

        // cascade resolution
        for (int i = 0; i < 6; i++) begin
            drive4(1'b1, cas_a[i], cas_b[i], cas_in[i]);
            step();
            check($sformatf("cascade_%0d", i), {28'd0, obs4()}, {28'd0, 1'b1, cas_exp[i]});
        end

        // MSB / LSB boundaries
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, edg_a[i], edg_b[i], 3'b010);
            step();
            check($sformatf("edge_%0d", i), {28'd0, obs4()}, {28'd0, 1'b1, edg_exp[i]});
        end

        // exhaustive WIDTH=4 sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic [2:0] e;
                e = (ia > ib) ? 3'b100 : (ia < ib) ? 3'b001 : 3'b010;
                drive4(1'b1, 4'(ia), 4'(ib), 3'b010);
                step();
                check($sformatf("sweep4_%0d_%0d", ia, ib), {28'd0, obs4()}, {28'd0, 1'b1, e});
            end
        end
        drive4(1'b0, 4'd0, 4'd0, 3'b010);

        // random WIDTH=8 pairs with random cascade flags
        for (int k = 0; k < 200; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [2:0] rc;
            logic [2:0] e;
            ra = 8'($urandom_range(0, 255));
            rb = (k % 4 == 0) ? ra : 8'($urandom_range(0, 255));
            rc = 3'($urandom_range(0, 7));
            if (ra > rb)
                e = 3'b100;
            else if (ra < rb)
                e = 3'b001;
            else if (rc[2])
                e = 3'b100;
            else if (rc[0])
                e = 3'b001;
            else
                e = 3'b010;
            bus8.in_valid = 1'b1;
            bus8.a        = ra;
            bus8.b        = rb;
            bus8.cas_gt   = rc[2];
            bus8.cas_eq   = rc[1];
            bus8.cas_lt   = rc[0];
            step();
            check($sformatf("rand8_%0d", k), {28'd0, obs8()}, {28'd0, 1'b1, e});
        end

        // WIDTH=8 extremes
        bus8.cas_gt = 1'b0;
        bus8.cas_eq = 1'b1;
        bus8.cas_lt = 1'b0;
        bus8.a = 8'h80; bus8.b = 8'h7F;
        step();
        check("w8_msb", {28'd0, obs8()}, {28'd0, 4'b1100});
        bus8.a = 8'hFF; bus8.b = 8'hFF;
        step();
        check("w8_ones", {28'd0, obs8()}, {28'd0, 4'b1010});
        bus8.a = 8'hFE; bus8.b = 8'hFF;
        step();
        check("w8_lsb", {28'd0, obs8()}, {28'd0, 4'b1001});
        bus8.in_valid = 1'b0;
        step();
        check("w8_hold", {28'd0, obs8()}, {28'd0, 4'b0001});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_4bit.md
Name: comp_4bit

Overview:
Registered magnitude comparator for two unsigned WIDTH-bit operands (default 4). It produces one-hot greater, equal and less flags one clock after a valid input. Cascade inputs let several instances chain into wider comparators. It sits in datapath control logic wherever a registered a-vs-b decision is needed.

Parameters:
WIDTH, 4, operand width in bits (>=1); all compares are unsigned.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands and cascade inputs are sampled on this clock edge when high
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
cas_gt  input  1  cascade "lower stage says greater"; tie 0 for standalone use
cas_eq  input  1  cascade "lower stage says equal"; tie 1 for standalone use
cas_lt  input  1  cascade "lower stage says less"; tie 0 for standalone use
out_valid  output  1  high for one cycle when the flags reflect a newly sampled compare
agtb  output  1  registered a > b
aeqb  output  1  registered a == b
altb  output  1  registered a < b

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset: on a clk edge with rst=1, agtb=0, aeqb=0, altb=0 and out_valid=0. rst has priority over in_valid.
- Latency is 1 cycle. For in_valid=1 at edge N, the flags and out_valid=1 are visible after edge N.
- in_valid=0 at an edge: out_valid goes to 0 and agtb/aeqb/altb hold their last values.
- Back-to-back in_valid is accepted every cycle (throughput 1/cycle). There is no backpressure.
- Compare rules, unsigned over the full WIDTH:
  - a > b: agtb=1, others 0.
  - a < b: altb=1, others 0.
  - a == b: resolved from the cascade inputs, in priority order:
    - cas_gt=1: agtb=1.
    - else cas_lt=1: altb=1.
    - else: aeqb=1. This includes the all-zero cascade case.
- Invariant: after the first valid sample following reset, exactly one of agtb/aeqb/altb is 1 on every cycle. Immediately after reset all three are 0.
- Reset asserted mid-stream: the flags clear on that edge. A valid input presented in the same cycle as rst=1 is discarded. The first valid sample after rst deasserts is handled normally.
- Cascading: the stage holding the least-significant bits feeds its registered agtb/aeqb/altb into the cas_* inputs of the next-more-significant stage. The latency adds one cycle per stage, and the user aligns valids accordingly.
- Boundaries that must be exact: all-zero operands, all-ones operands, and operands differing only in the MSB or only in the LSB.

Test Plan:
- Basic sequence with cascade tied to 0/1/0 and in_valid=1, one pair per cycle: a/b = 0000/0000, 0010/0001, 0100/1000, 1111/1111, 0001/0010, 1100/1011 -> one cycle later, agtb/aeqb/altb = 010, 100, 001, 010, 001, 100 respectively, with out_valid=1 each cycle.
- Reset behaviour: assert rst while a=1100, b=1011, in_valid=1 -> next edge all flags 0 and out_valid=0. Deassert rst -> the next valid sample gives agtb=1.
- Hold on invalid: load 0100/1000 (altb=1), then in_valid=0 with a=1111, b=0000 for 3 cycles -> altb stays 1 and out_valid=0 throughout.
- Cascade resolution with a=b=1010: cas 1/0/0 -> agtb; 0/0/1 -> altb; 0/1/0 -> aeqb; 1/0/1 -> agtb; 0/0/0 -> aeqb. With a=0001, b=0000 and cas 0/0/1 -> agtb, since the operands dominate.
- MSB/LSB edges: 1000 vs 0111 -> agtb; 0000 vs 0001 -> altb; 1111 vs 1110 -> agtb.
- Exhaustive sweep of all 256 a/b pairs at WIDTH=4 with a scoreboard: flags are one-hot and match the unsigned compare. Repeat for WIDTH=8 with random pairs.
